// File: rtl/alu_word_seq_pkg.sv
// Shared definitions for the word sequencer: opcodes, array select codes,
// FSM state type and the opcode decode function.
package alu_word_seq_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned SEL_W = 2;

  localparam logic [OP_W-1:0] OP_ADD  = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB  = 3'b001;
  localparam logic [OP_W-1:0] OP_INC  = 3'b010;
  localparam logic [OP_W-1:0] OP_DEC  = 3'b011;
  localparam logic [OP_W-1:0] OP_PASS = 3'b100;

  // Array operand-B select: constant zero, B, ~B, all ones
  localparam logic [SEL_W-1:0] SEL_ZERO = 2'b00;
  localparam logic [SEL_W-1:0] SEL_B    = 2'b01;
  localparam logic [SEL_W-1:0] SEL_NB   = 2'b10;
  localparam logic [SEL_W-1:0] SEL_ONES = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Decoded array controls for one opcode
  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             cin0;
    logic             err;
  } dec_t;

  // Reserved opcodes behave as PASS but raise err
  function automatic dec_t op_decode(input logic [OP_W-1:0] op);
    dec_t d;
    d.sel  = SEL_ZERO;
    d.cin0 = 1'b0;
    d.err  = 1'b0;
    case (op)
      OP_ADD:  begin d.sel = SEL_B;    d.cin0 = 1'b0; end
      OP_SUB:  begin d.sel = SEL_NB;   d.cin0 = 1'b1; end
      OP_INC:  begin d.sel = SEL_ZERO; d.cin0 = 1'b1; end
      OP_DEC:  begin d.sel = SEL_ONES; d.cin0 = 1'b0; end
      OP_PASS: begin d.sel = SEL_ZERO; d.cin0 = 1'b0; end
      default: begin d.sel = SEL_ZERO; d.cin0 = 1'b0; d.err = 1'b1; end
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_word_seq_dec.sv
// Combinational opcode decoder for the arithmetic element array.
//   op_i  : opcode
//   dec_c : {alu_s select, chunk-0 carry-in, reserved-opcode flag}
module alu_word_seq_dec
  import alu_word_seq_pkg::*;
(
  input  logic [OP_W-1:0] op_i,
  output dec_t            dec_c
);

  assign dec_c = op_decode(op_i);

endmodule

// File: rtl/alu_word_seq.sv
// Multi-cycle word sequencer: takes a K*N-bit request, issues it to an
// external N-bit ALU slice one chunk per cycle (LSB first, carry chained),
// then returns the assembled result and flags.
//   clk, rst_n            : clock, async active-low reset
//   in_valid/in_ready     : request handshake with op, a, b
//   alu_m/s/a/b/cin       : controls and operands to the slice (ISSUE only)
//   alu_y, alu_cout       : slice sum and carry-out
//   out_valid/out_ready   : result handshake with result, cout, zero, err
module alu_word_seq
  import alu_word_seq_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned K = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [N*K-1:0]   a,
  input  logic [N*K-1:0]   b,
  output logic             alu_m,
  output logic [SEL_W-1:0] alu_s,
  output logic [N-1:0]     alu_a,
  output logic [N-1:0]     alu_b,
  output logic             alu_cin,
  input  logic [N-1:0]     alu_y,
  input  logic             alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N*K-1:0]   result,
  output logic             cout,
  output logic             zero,
  output logic             err
);

  localparam int unsigned W     = N * K;
  localparam int unsigned IDX_W = (K > 1) ? $clog2(K) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K - 1);

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [W-1:0]      a_q, a_d;
  logic [W-1:0]      b_q, b_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              cin0_q, cin0_d;
  logic              carry_q, carry_d;
  logic [W-1:0]      result_q, result_d;
  logic              cout_q, cout_d;
  logic              zero_q, zero_d;
  logic              err_q, err_d;
  dec_t              dec;

  alu_word_seq_dec u_dec (
    .op_i  (op),
    .dec_c (dec)
  );

  // Next-state and datapath capture
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    a_d      = a_q;
    b_d      = b_q;
    sel_d    = sel_q;
    cin0_d   = cin0_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    err_d    = err_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sel_d   = dec.sel;
          cin0_d  = dec.cin0;
          err_d   = dec.err;
          idx_d   = '0;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        result_d[idx_q*N +: N] = alu_y;
        carry_d = alu_cout;
        if (idx_q == IDX_LAST) begin
          cout_d  = alu_cout;
          zero_d  = (result_d == '0);
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = IDX_W'(idx_q + 1'b1);
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      sel_q    <= SEL_ZERO;
      cin0_q   <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sel_q    <= sel_d;
      cin0_q   <= cin0_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      err_q    <= err_d;
    end
  end

  // Slice drive: decoded only from registers, zero outside ISSUE
  always_comb begin
    alu_s   = SEL_ZERO;
    alu_a   = '0;
    alu_b   = '0;
    alu_cin = 1'b0;
    if (state_q == ST_ISSUE) begin
      alu_s   = sel_q;
      alu_a   = a_q[idx_q*N +: N];
      alu_b   = b_q[idx_q*N +: N];
      alu_cin = (idx_q == '0) ? cin0_q : carry_q;
    end
  end

  assign alu_m     = 1'b0;
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign cout      = cout_q;
  assign zero      = zero_q;
  assign err       = err_q;

endmodule

// File: tb/tb_alu_word_seq.sv
// Directed bench for alu_word_seq with a behavioural ALU slice and a
// queue of expected results.
module tb_alu_word_seq;

  localparam int unsigned N = 8;
  localparam int unsigned K = 4;
  localparam int unsigned W = N * K;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    op = '0;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic          alu_m;
  logic [1:0]    alu_s;
  logic [N-1:0]  alu_a;
  logic [N-1:0]  alu_b;
  logic          alu_cin;
  logic [N-1:0]  alu_y;
  logic          alu_cout;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  result;
  logic          cout;
  logic          zero;
  logic          err;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         e;
    logic [1:0]   s;
    logic         cin;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;

  alu_word_seq #(.N(N), .K(K)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b),
    .alu_m(alu_m), .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin),
    .alu_y(alu_y), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .zero(zero), .err(err)
  );

  always #5 clk = ~clk;

  // Behavioural slice: y,cout = a + sel(s,b) + cin
  logic [N-1:0] selb;
  always_comb begin
    case (alu_s)
      2'b00:   selb = '0;
      2'b01:   selb = alu_b;
      2'b10:   selb = ~alu_b;
      default: selb = '1;
    endcase
    {alu_cout, alu_y} = {1'b0, alu_a} + {1'b0, selb} + (N+1)'(alu_cin);
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Word-level arithmetic reference
  function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    e.e = 1'b0;
    case (o)
      3'b000: begin {e.c, e.res} = {1'b0, x} + {1'b0, y}; e.s = 2'b01; e.cin = 1'b0; end
      3'b001: begin e.res = x - y; e.c = (x >= y); e.s = 2'b10; e.cin = 1'b1; end
      3'b010: begin e.res = x + 1; e.c = (x == '1); e.s = 2'b00; e.cin = 1'b1; end
      3'b011: begin e.res = x - 1; e.c = (x != '0); e.s = 2'b11; e.cin = 1'b0; end
      default: begin e.res = x; e.c = 1'b0; e.s = 2'b00; e.cin = 1'b0; e.e = (o != 3'b100); end
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, W'(in_ready), W'(1));
    chk({tag, "_out_valid"}, W'(out_valid), W'(0));
    chk({tag, "_result"}, result, '0);
    chk({tag, "_flags"}, W'({cout, zero, err}), W'(0));
    chk({tag, "_alu_ctl"}, W'({alu_m, alu_s, alu_cin}), W'(0));
    chk({tag, "_alu_ab"}, W'({alu_a, alu_b}), W'(0));
  endtask

  // Present a request and return #1 after the accepting edge
  task automatic send(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    int n = 0;
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1;
    while (!in_ready && n < 100) begin @(negedge clk); n++; end
    chk("accept_timeout", W'(n < 100), W'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    q.push_back(model(o, x, y));
  endtask

  // Wait for out_valid, checking issue controls and latency
  task automatic wait_done();
    int n = 0;
    exp_t e = q[0];
    @(negedge clk);
    chk("issue_ctl", W'({alu_m, alu_s, alu_cin}), W'({1'b0, e.s, e.cin}));
    chk("issue_in_ready", W'(in_ready), W'(0));
    while (!out_valid && n < 50) begin n++; @(negedge clk); end
    chk("latency", W'(n), W'(K));
  endtask

  // Compare the head of the queue and complete the output handshake
  task automatic collect(input string tag);
    exp_t e;
    if (q.size() == 0) begin
      chk({tag, "_queue_empty"}, W'(0), W'(1));
    end else begin
      e = q.pop_front();
      chk({tag, "_result"}, result, e.res);
      chk({tag, "_cout_zero_err"}, W'({cout, zero, err}), W'({e.c, e.z, e.e}));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk({tag, "_post_valid"}, W'(out_valid), W'(0));
    chk({tag, "_post_ready"}, W'(in_ready), W'(1));
  endtask

  task automatic run(input string tag, input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    send(o, x, y);
    wait_done();
    collect(tag);
  endtask

  initial begin
    exp_t e;
    logic [W-1:0] ra, rb;

    #2;
    check_reset_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("idle");

    run("add_carry", 3'b000, 32'h0000_00FF, 32'h0000_0001);
    run("sub_eq",    3'b001, 32'h0000_0005, 32'h0000_0005);
    run("inc_wrap",  3'b010, 32'hFFFF_FFFF, 32'h0);
    run("dec_zero",  3'b011, 32'h0,         32'h0);
    run("pass",      3'b100, 32'hCAFE_F00D, 32'h1111_1111);
    run("rsvd",      3'b110, 32'h1234_5678, 32'h0);
    run("add_after", 3'b000, 32'h0101_0101, 32'h1010_1010);
    run("sub_borrow",3'b001, 32'h0000_0003, 32'h0000_0007);
    for (int i = 0; i < 6; i++) begin
      ra = $urandom; rb = $urandom;
      run("rand", 3'(i % 4), ra, rb);
    end

    // Backpressure with a request pending during DONE
    send(3'b000, 32'h8000_0000, 32'h8000_0000);
    wait_done();
    e = q[0];
    op = 3'b001; a = 32'h0000_1000; b = 32'h0000_0001; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", W'(out_valid), W'(1));
      chk("bp_in_ready", W'(in_ready), W'(0));
      chk("bp_result", result, e.res);
      @(negedge clk);
    end
    void'(q.pop_front());
    chk("bp_final", W'({cout, zero, err}), W'({e.c, e.z, e.e}));
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    chk("bp_pending_ready", W'(in_ready), W'(1));
    @(posedge clk);
    #1 in_valid = 1'b0;
    q.push_back(model(3'b001, 32'h0000_1000, 32'h0000_0001));
    chk("bp_pending_taken", W'(in_ready), W'(0));
    wait_done();
    collect("bp_pending");

    // Reset in the middle of ISSUE (idx=2)
    send(3'b000, 32'h0F0F_0F0F, 32'h0101_0101);
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    void'(q.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("midrst_no_valid", W'({out_valid, in_ready}), W'(2'b01));
    end
    run("add_fresh", 3'b000, 32'h7FFF_FFFF, 32'h0000_0001);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_word_seq.md
# alu_word_seq

Multi-cycle word sequencer that drives the N-bit arithmetic element array and its adder slice from the control side. Accepts a K×N-bit arithmetic request on a valid/ready handshake, decodes the opcode into the array's mode/select/carry-in controls, and issues the word one N-bit chunk per cycle, LSB chunk first, with carry chaining. It then assembles the K-chunk result and flags and returns them on a second valid/ready handshake. It sits between the instruction/control logic and the combinational ALU slice, which comprises the arithmetic element array plus adder.

## Interface
- N, 8, slice width in bits
- K, 4, chunks per word (K ≥ 1); word width W = N*K
- clk  in  1  clock, rising edge
- rst_n  in  1  reset; one clock, asynchronous, active-low
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid & in_ready
- op  in  3  opcode
- a  in  W  operand A
- b  in  W  operand B
- alu_m  out  1  array mode; always 0 (arithmetic)
- alu_s  out  2  array select: 00→0, 01→b, 10→~b, 11→all ones
- alu_a  out  N  current A chunk
- alu_b  out  N  current B chunk
- alu_cin  out  1  slice carry-in
- alu_y  in  N  slice sum, combinational from the alu_* outputs
- alu_cout  in  1  slice carry-out
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid & out_ready
- result  out  W  assembled result
- cout  out  1  carry-out of the top chunk
- zero  out  1  result == 0
- err  out  1  reserved opcode was issued

## Operation
- Opcode decode, giving (alu_s, chunk-0 cin):
  - ADD 000 = (01,0)
  - SUB 001 = (10,1)
  - INC 010 = (00,1)
  - DEC 011 = (11,0)
  - PASS 100 = (00,0)
  - 101–111 are reserved and decode as PASS with err=1.
- FSM states are IDLE, ISSUE, DONE.
- IDLE:
  - in_ready=1.
  - On handshake, latch op, a and b, set chunk index idx=0, and go to ISSUE.
- ISSUE:
  - Combinational outputs: alu_a = a[idx*N +: N] and alu_b = b[idx*N +: N].
  - alu_cin = decoded cin for idx=0, otherwise the carry captured from the previous chunk.
  - Each cycle, capture alu_y into result[idx*N +: N] and alu_cout into the carry register, then increment idx.
  - After chunk K-1, go to DONE.
- DONE:
  - out_valid=1.
  - result, cout, zero and err are held stable until handshake, then the block returns to IDLE.
- Outside ISSUE, alu_s, alu_a, alu_b and alu_cin are driven to 0.
- cout is the raw slice carry from chunk K-1; SUB borrow is !cout.
- zero is evaluated on the fully assembled result.
- Arithmetic is modulo 2^W, with no saturation.

## Timing
- Reset values:
  - in_ready=1
  - out_valid=0
  - result=0, cout=0, zero=0, err=0
  - alu_m=0, alu_s=00, alu_a=0, alu_b=0, alu_cin=0
  - state=IDLE, idx=0
- Latency:
  - Request handshake at edge E.
  - ISSUE occupies cycles E+1 … E+K.
  - out_valid rises after edge E+K.
- If out_ready is already high, the output handshake completes at edge E+K+1, and in_ready is high again in the following cycle.
- There is no back-to-back overlap: in_ready=0 throughout ISSUE and DONE. Peak throughput is one word per K+2 cycles.
- in_valid held high during ISSUE or DONE has no effect. The pending request is accepted only once the block is back in IDLE.
- out_ready is ignored unless out_valid=1.
- K=1: a single ISSUE cycle, and the chunk-0 cin rule applies.
- idx wraps only through reset or return to IDLE; it never exceeds K-1.
- Reset asserted mid-ISSUE or mid-DONE aborts the operation immediately. All outputs take their reset values and no out_valid is produced for the aborted request.

## Structure
- A shared package holds:
  - opcode constants
  - the alu_s encodings SEL_ZERO, SEL_B, SEL_NB, SEL_ONES
  - the FSM state typedef
  - the decode function from op to {s, cin0, err}
- One sub-module is natural: alu_op_dec, a purely combinational opcode→control decoder, reused by the control unit.
- The ALU slice (the arithmetic element array plus adder) is external. The bench provides a behavioural model: alu_y,alu_cout = alu_a + sel(alu_s, alu_b) + alu_cin.

## Test plan
Defaults N=8, K=4.
- ADD a=0x0000_00FF, b=0x0000_0001 → result=0x0000_0100, cout=0, zero=0. Carry propagates from chunk 0 to chunk 1. out_valid appears K=4 cycles after accept.
- SUB a=0x0000_0005, b=0x0000_0005 → result=0, cout=1, zero=1, err=0.
- INC a=0xFFFF_FFFF → result=0, cout=1, zero=1. DEC a=0 → result=0xFFFF_FFFF, cout=0.
- op=110, a=0x1234_5678 → result=0x1234_5678, err=1. The next valid ADD returns err=0.
- Backpressure: out_ready held low 10 cycles. Outputs stay stable, in_ready=0 and a pending in_valid is not accepted. The request is accepted in the cycle after the output handshake.
- Assert rst_n low at ISSUE idx=2. All outputs return to reset values and in_ready=1 after release. No spurious out_valid appears, and a fresh ADD then completes correctly.
